// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, immediate format enum and decoded bundle for the decode stage
package rv_pkg;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_fmt_e    imm_fmt;
    logic [11:0] imm12;
    logic        illegal;
  } dec_bundle_t;
endpackage

// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: instruction in / decoded bundle out handshake bus plus statistics
interface rv_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [2:0]       out_imm_fmt;
  logic [11:0]      out_imm12;
  logic             out_illegal;
  logic [CNT_W-1:0] stat_instr_cnt;
  logic [CNT_W-1:0] stat_illegal_cnt;
  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7, out_imm_fmt, out_imm12, out_illegal, stat_instr_cnt, stat_illegal_cnt
  );
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7, out_imm_fmt, out_imm12, out_illegal, stat_instr_cnt, stat_illegal_cnt
  );
endinterface

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: pure combinational split of an RV32I word into a decoded bundle
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output dec_bundle_t     dec
);
  // field split, format classification and packed 12-bit immediate selection
  always_comb begin
    dec.opcode  = instr[6:0];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.imm_fmt = FMT_NONE;
    dec.illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: dec.imm_fmt = FMT_I;
      OP_STORE:         dec.imm_fmt = FMT_S;
      OP_BRANCH:        dec.imm_fmt = FMT_B;
      OP_LUI, OP_AUIPC: dec.imm_fmt = FMT_U;
      OP_JAL:           dec.imm_fmt = FMT_J;
      OP_OP:            dec.imm_fmt = FMT_NONE;
      default:          dec.illegal = 1'b1;
    endcase
    dec.imm12 = dec.imm_fmt == FMT_I ? instr[31:20] :
                dec.imm_fmt == FMT_S ? {instr[31:25], instr[11:7]} :
                dec.imm_fmt == FMT_B ? {instr[31], instr[7], instr[30:25], instr[11:8]} : 12'd0;
  end
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode with skid buffer; RV_DECODE_STATS_EN adds counters
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  rv_decode_stage_if.slave bus
);
  dec_bundle_t dec, m_q, s_q;
  logic m_valid, s_valid;
  logic accept, xfer, m_free;
  rv_decode_comb #(.XLEN(XLEN)) u_dec (.instr(bus.in_instr), .dec(dec));
  assign accept = bus.in_valid & ~s_valid & ~bus.flush;
  assign xfer   = m_valid & bus.out_ready;
  assign m_free = ~m_valid | xfer;
  // main register and valid bits; flush wins, then skid drain, then fresh load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid & xfer) begin
      m_q     <= s_q;
      s_valid <= 1'b0;
    end else if (accept & m_free) begin
      m_q     <= dec;
      m_valid <= 1'b1;
    end else if (accept) begin
      s_valid <= 1'b1;
    end else if (xfer) begin
      m_valid <= 1'b0;
    end
  end
  // skid data only captures when M is held; its contents matter only while s_valid
  always_ff @(posedge clk) begin
    if (accept & ~m_free) s_q <= dec;
  end
  assign bus.in_ready    = ~s_valid;
  assign bus.out_valid   = m_valid;
  assign bus.out_opcode  = m_q.opcode;
  assign bus.out_rd      = m_q.rd;
  assign bus.out_rs1     = m_q.rs1;
  assign bus.out_rs2     = m_q.rs2;
  assign bus.out_funct3  = m_q.funct3;
  assign bus.out_funct7  = m_q.funct7;
  assign bus.out_imm_fmt = m_q.imm_fmt;
  assign bus.out_imm12   = m_q.imm12;
  assign bus.out_illegal = m_q.illegal;
`ifdef RV_DECODE_STATS_EN
  logic [CNT_W-1:0] instr_cnt, illegal_cnt;
  // count accepted instructions and the illegal ones among them, wrapping freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (accept) begin
      instr_cnt   <= instr_cnt + CNT_W'(1);
      illegal_cnt <= illegal_cnt + CNT_W'(dec.illegal);
    end
  end
  assign bus.stat_instr_cnt   = instr_cnt;
  assign bus.stat_illegal_cnt = illegal_cnt;
`else
  assign bus.stat_instr_cnt   = {CNT_W{1'b0}};
  assign bus.stat_illegal_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered instruction-decode stage of the RV32I core, between the IF/ID instruction register and the 12→32 immediate sign extender / operand muxes.
- Splits each 32-bit instruction into register indices, funct fields, format class and a packed 12-bit immediate field. The extender consumes the immediate field directly.
- Valid/ready handshake with a one-entry skid buffer, so a stall downstream loses no instruction and costs no bubble.

Parameters:
- XLEN, 32, instruction/data width.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch taken / trap).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  XLEN  raw instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm_fmt  out  3  immediate format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_imm12  out  12  packed 12-bit immediate for the sign extender.
- out_illegal  out  1  unsupported opcode.
- stat_instr_cnt  out  CNT_W  accepted-instruction count (optional feature).
- stat_illegal_cnt  out  CNT_W  accepted illegal-instruction count (optional feature).

Behaviour:
- Reset (async, rst=1): all out_* = 0, both valid bits = 0, in_ready = 1, counters = 0.
- Handshakes:
  - Accept on in_valid & in_ready.
  - Transfer out on out_valid & out_ready.
  - Latency: 1 cycle from accept to out_valid.
- Storage: main output register M plus skid register S.
  - in_ready = ~S.valid (registered, not combinational from out_ready).
- Per-cycle update:
  - Accept while M is empty or M transfers: the decoded word loads M.
  - Accept while M holds and does not transfer: the decoded word loads S.
  - M transfers while S is valid: S moves to M and S.valid clears.
  - Order is always preserved.
- Decode classes:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011, MISC-MEM 0001111 → imm12 = instr[31:20].
  - S: STORE 0100011 → imm12 = {instr[31:25], instr[11:7]}.
  - B: BRANCH 1100011 → imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]} (offset bits 12:1).
  - U: LUI 0110111, AUIPC 0010111 → fmt 4, imm12 = 0.
  - J: JAL 1101111 → fmt 4/5 respectively (JAL is 5), imm12 = 0.
  - NONE: OP 0110011 → fmt 0, imm12 = 0.
  - Any other opcode, or instr[1:0] != 2'b11 → illegal = 1, fmt 0, imm12 = 0. Other fields are still decoded.
- flush:
  - Clears M.valid and S.valid next edge.
  - Drops any same-cycle input; in_ready forced to 1 the following cycle.
  - flush has priority over accept and transfer.
- Data registers need no reset beyond valid bits, except out_* must read 0 after reset.

Optional Feature:
- Macro: RV_DECODE_STATS_EN.
- Defined:
  - stat_instr_cnt increments on each accepted (not flushed) instruction.
  - stat_illegal_cnt increments when that instruction is illegal.
  - Both counters wrap modulo 2^CNT_W and are cleared only by rst.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams.
  - imm_fmt_e enum (3 bits).
  - decoded-bundle struct dec_bundle_t.
- Sub-module rv_decode_comb: pure combinational instr → dec_bundle_t. Instantiated once on the input path.
- The stage itself holds only the M/S registers and handshake.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle:
  - out_valid=1, fmt=1, imm12=0xFFF, rd=1, rs1=0, illegal=0.
- SW x2,8(x1) (0x0020A423) → fmt=2, imm12=0x008, rs1=1, rs2=2, funct3=2.
- Backpressure: out_ready=0, three back-to-back valid instrs A,B,C →
  - A held in M, B in S, in_ready=0, C stalled.
  - Raise out_ready → A,B,C emerge in order with no gap.
- flush asserted while M and S are both full → next cycle out_valid=0, in_ready=1; the same-cycle input is never output.
- 0x00000000 and LUI 0x123450B7 →
  - First: illegal=1, imm12=0.
  - Second: fmt=4, rd=1, illegal=0.
  - With RV_DECODE_STATS_EN: stat_instr_cnt=2, stat_illegal_cnt=1.
- rst pulsed asynchronously mid-stall → outputs 0 immediately, in_ready=1, no stale bundle after release.
